// File: rtl/io_bit_rmw_pkg.sv
// Shared definitions for the I/O bit read-modify-write unit:
// op codes, FSM state encoding and the bit-number decoder.
package io_bit_rmw_pkg;

  localparam logic [2:0] OP_SBI  = 3'b000;
  localparam logic [2:0] OP_CBI  = 3'b001;
  localparam logic [2:0] OP_TBI  = 3'b010;
  localparam logic [2:0] OP_SBIS = 3'b011;
  localparam logic [2:0] OP_SBIC = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // One-hot mask wide enough for the largest supported register width.
  function automatic logic [31:0] bit_mask(input logic [4:0] bit_num);
    return 32'd1 << bit_num;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_SBIC;
  endfunction

  function automatic logic op_is_test(input logic [2:0] op);
    return (op == OP_SBIS) || (op == OP_SBIC);
  endfunction

endpackage

// File: rtl/io_bit_rmw_unit_tmo.sv
// Bus-phase timeout counter; o_sat flags the stall cycle that brings
// the count to all-ones, which is when the phase must be abandoned.
module rmw_timeout_cnt #(
  parameter int TMO_W = 4
) (
  input  logic cp2,
  input  logic ireset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sat
);

  localparam logic [TMO_W-1:0] MAX = '1;

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  assign o_sat = i_en && (r_cnt == (MAX - TMO_W'(1)));

endmodule

// File: rtl/io_bit_rmw_unit.sv
// Multi-cycle SBI/CBI/TBI/SBIS/SBIC engine driving the I/O bus with
// wait-state handshaking and a per-phase timeout.
module io_bit_rmw_unit
  import io_bit_rmw_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BIT_W  = 3,
  parameter int ADDR_W = 6,
  parameter int TMO_W  = 4
) (
  input  logic              cp2,
  input  logic              ireset,
  input  logic              cp2en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BIT_W-1:0]  req_bit,
  output logic [ADDR_W-1:0] io_adr,
  output logic              io_re,
  output logic              io_we,
  output logic [DATA_W-1:0] io_dout,
  input  logic [DATA_W-1:0] io_din,
  input  logic              io_rdy,
  output logic              done,
  output logic              test_result,
  output logic              err
);

  state_t              r_state;
  logic [2:0]          r_op;
  logic [BIT_W-1:0]    r_bit;
  logic [ADDR_W-1:0]   r_io_adr;
  logic                r_io_re;
  logic                r_io_we;
  logic [DATA_W-1:0]   r_io_dout;
  logic                r_done;
  logic                r_test;
  logic                r_err;

  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_mod;
  logic                w_bitval;
  logic                w_test;
  logic                w_tmo_clr;
  logic                w_tmo_en;
  logic                w_tmo_sat;

  assign w_mask   = DATA_W'(bit_mask(5'(r_bit)));
  assign w_bitval = |(io_din & w_mask);
  assign w_test   = (r_op == OP_SBIS) ? w_bitval : !w_bitval;

  always_comb begin
    w_mod = io_din | w_mask;
    case (r_op)
      OP_CBI:  w_mod = io_din & ~w_mask;
      OP_TBI:  w_mod = io_din ^ w_mask;
      default: ;
    endcase
  end

  // Counter restarts whenever a fresh bus phase is about to begin.
  assign w_tmo_clr = cp2en && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                               ((r_state == ST_RD) && io_rdy));
  assign w_tmo_en  = cp2en && !io_rdy && ((r_state == ST_RD) || (r_state == ST_WR));

  rmw_timeout_cnt #(
    .TMO_W (TMO_W)
  ) u_tmo (
    .cp2    (cp2),
    .ireset (ireset),
    .i_clr  (w_tmo_clr),
    .i_en   (w_tmo_en),
    .o_sat  (w_tmo_sat)
  );

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_bit     <= '0;
      r_io_adr  <= '0;
      r_io_re   <= 1'b0;
      r_io_we   <= 1'b0;
      r_io_dout <= '0;
      r_done    <= 1'b0;
      r_test    <= 1'b0;
      r_err     <= 1'b0;
    end else if (cp2en) begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op     <= req_op;
            r_bit    <= req_bit;
            r_io_adr <= req_addr;
            r_test   <= 1'b0;
            if (op_legal(req_op)) begin
              r_state <= ST_RD;
              r_io_re <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (io_rdy) begin
            r_io_re <= 1'b0;
            if (op_is_test(r_op)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_test  <= w_test;
            end else begin
              r_state   <= ST_WR;
              r_io_we   <= 1'b1;
              r_io_dout <= w_mod;
            end
          end else if (w_tmo_sat) begin
            r_io_re <= 1'b0;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        ST_WR: begin
          if (io_rdy) begin
            r_io_we <= 1'b0;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (w_tmo_sat) begin
            r_io_we <= 1'b0;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign io_adr      = r_io_adr;
  assign io_re       = r_io_re;
  assign io_we       = r_io_we;
  assign io_dout     = r_io_dout;
  assign done        = r_done;
  assign test_result = r_test;
  assign err         = r_err;

endmodule
